dispatch_queue: RTL

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue_pkg.sv | 37 +++
 rtl/dispatch_fifo.sv | 64 ++++++
 rtl/dispatch_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared constants for the dispatch queue: op encodings, load/store op range,
// boolean constants, the zero rename tag and the run/flush state encoding.
package dispatch_queue_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned OP_ENUM_W = 6;
  localparam int unsigned TAG_ZERO  = 0;

  typedef enum logic [OP_ENUM_W-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_BEQ = 6'd8,
    OP_JAL = 6'd9,
    OP_LB  = 6'd16,
    OP_LW  = 6'd18,
    OP_SB  = 6'd20,
    OP_SW  = 6'd22
  } op_e;

  localparam logic [OP_ENUM_W-1:0] OP_LS_FIRST = OP_LB;
  localparam logic [OP_ENUM_W-1:0] OP_LS_LAST  = OP_SW;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic is_ls_op(input logic [OP_ENUM_W-1:0] op);
    return (op >= OP_LS_FIRST) && (op <= OP_LS_LAST);
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Decoded-instruction FIFO: power-of-two depth, wrapping pointers, and a
// separate occupancy count that distinguishes full from empty.
module dispatch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         clr_in,
  input  logic         push_in,
  input  logic         pop_in,
  input  logic [W-1:0] wdata_in,
  output logic [W-1:0] rdata_out,
  output logic         full_out,
  output logic         empty_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic                    push_ok, pop_ok;

  assign full_out  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_out = (cnt_q == '0);
  assign rdata_out = mem_q[rptr_q];
  assign push_ok   = push_in && !full_out;
  assign pop_ok    = pop_in && !empty_out;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    if (clr_in) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wdata_in;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop_ok) rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers decoded instructions, resolves operands at the FIFO
// head and issues to RS/LSB/ROB. Define DISPATCH_CDB_BYPASS_EN for CDB forwarding.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned OP_W    = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     in_valid_in,
  output logic                     in_ready_out,
  input  logic [OP_W-1:0]          in_op_in,
  input  logic                     in_mem_in,
  input  logic                     in_pred_in,
  input  logic [14:0]              in_regs_in,
  input  logic [31:0]              in_imm_in,
  input  logic [31:0]              in_pc_in,
  input  logic [31:0]              in_rbpc_in,
  output logic [4:0]               rs1_out,
  output logic [4:0]               rs2_out,
  input  logic [63:0]              rf_v_in,
  input  logic [2*ROB_W-1:0]       rf_q_in,
  input  logic [1:0]               rf_busy_in,
  input  logic [1:0]               rob_rdy_in,
  input  logic [63:0]              rob_data_in,
  input  logic [NUM_CDB-1:0]       cdb_valid_in,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag_in,
  input  logic [NUM_CDB*32-1:0]    cdb_data_in,
  input  logic [ROB_W-1:0]         rob_tag_in,
  input  logic                     rob_full_in,
  input  logic                     rs_full_in,
  input  logic                     lsb_full_in,
  output logic                     rob_alloc_out,
  output logic                     rs_valid_out,
  output logic                     lsb_valid_out,
  output logic                     rename_en_out,
  output logic [OP_W-1:0]          iss_op_out,
  output logic [63:0]              iss_v_out,
  output logic [2*ROB_W-1:0]       iss_q_out,
  output logic [1:0]               iss_busy_out,
  output logic [31:0]              iss_imm_out,
  output logic [31:0]              iss_pc_out,
  output logic [31:0]              iss_rbpc_out,
  output logic [4:0]               iss_rd_out,
  output logic [ROB_W-1:0]         iss_tag_out,
  output logic                     iss_pred_out,
  input  logic                     rollback_in
);

  localparam int unsigned ENT_W = OP_W + 113;
  localparam int unsigned ISS_W = OP_W + 64 + 2*ROB_W + 2 + 96 + 5 + ROB_W + 1;
  localparam logic [ROB_W-1:0] TAG_Z = ROB_W'(TAG_ZERO);

  state_e             state_q, state_d;
  logic [ISS_W-1:0]   iss_q, iss_d;
  logic [3:0]         strb_q, strb_d;

  logic               fifo_full, fifo_empty, fifo_clr, fifo_push, fire, stall;
  logic [ENT_W-1:0]   wdata, head;
  logic [OP_W-1:0]    h_op;
  logic               h_mem, h_pred;
  logic [4:0]         h_rd;
  logic [31:0]        h_imm, h_pc, h_rbpc;
  logic [63:0]        opv;
  logic [2*ROB_W-1:0] opq;
  logic [1:0]         opbusy, cdb_hit;

  assign wdata = {in_op_in, in_mem_in, in_pred_in, in_regs_in, in_imm_in, in_pc_in, in_rbpc_in};
  assign {h_op, h_mem, h_pred, h_rd, rs1_out, rs2_out, h_imm, h_pc, h_rbpc} = head;

  // rdy_in joins the ready term so a frozen queue never accepts a handshake it drops.
  assign in_ready_out = !fifo_full && (state_q == ST_RUN) && rdy_in;
  assign fifo_push    = in_valid_in && in_ready_out;
  assign fifo_clr     = rdy_in && (state_q == ST_RUN) && rollback_in;
  assign fire         = !fifo_empty && rdy_in && (state_q == ST_RUN) && !rollback_in &&
                        !rob_full_in && !(h_mem ? lsb_full_in : rs_full_in) && !stall;

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clr_in    (fifo_clr),
    .push_in   (fifo_push),
    .pop_in    (fire),
    .wdata_in  (wdata),
    .rdata_out (head),
    .full_out  (fifo_full),
    .empty_out (fifo_empty)
  );

  // Priority per operand: CDB (lowest channel) > ROB ready > rename tag > RF value.
  always_comb begin
    opv     = '0;
    opq     = {2{TAG_Z}};
    opbusy  = '0;
    cdb_hit = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (rob_rdy_in[i]) begin
        opv[i*32 +: 32] = rob_data_in[i*32 +: 32];
      end else if (rf_busy_in[i]) begin
        opbusy[i]               = TRUE;
        opq[i*ROB_W +: ROB_W]   = rf_q_in[i*ROB_W +: ROB_W];
      end else begin
        opv[i*32 +: 32] = rf_v_in[i*32 +: 32];
      end
      for (int unsigned c = 0; c < NUM_CDB; c++) begin
        if (!cdb_hit[i] && rf_busy_in[i] && cdb_valid_in[c] &&
            (cdb_tag_in[c*ROB_W +: ROB_W] == rf_q_in[i*ROB_W +: ROB_W])) begin
          cdb_hit[i] = TRUE;
`ifdef DISPATCH_CDB_BYPASS_EN
          opv[i*32 +: 32]       = cdb_data_in[c*32 +: 32];
          opbusy[i]             = FALSE;
          opq[i*ROB_W +: ROB_W] = TAG_Z;
`endif
        end
      end
    end
  end

`ifdef DISPATCH_CDB_BYPASS_EN
  assign stall = FALSE;
`else
  // Without forwarding, wait a cycle for the broadcast value to land in the ROB/RF.
  logic unused_cdb_data;
  assign unused_cdb_data = ^cdb_data_in;
  assign stall = |(cdb_hit & rf_busy_in & ~rob_rdy_in);
`endif

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_RUN:   if (rollback_in) state_d = ST_FLUSH;
        ST_FLUSH: state_d = rollback_in ? ST_FLUSH : ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    iss_d  = iss_q;
    strb_d = '0;
    if (fire) begin
      iss_d  = {h_op, opv, opq, opbusy, h_imm, h_pc, h_rbpc, h_rd, rob_tag_in, h_pred};
      strb_d = {TRUE, !h_mem, h_mem, h_rd != 5'd0};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_RUN;
      iss_q   <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      strb_q  <= strb_d;
    end
  end

  assign {rob_alloc_out, rs_valid_out, lsb_valid_out, rename_en_out} = strb_q;
  assign {iss_op_out, iss_v_out, iss_q_out, iss_busy_out, iss_imm_out, iss_pc_out,
          iss_rbpc_out, iss_rd_out, iss_tag_out, iss_pred_out} = iss_q;

endmodule
